// File: rtl/sdram_req_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_req_arbiter_if                                                 |
// | Client-side byte bus plus toggle-handshake SDRAM bus for the arbiter.|
// | slave = arbiter; master = clients and SDRAM controller together.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sdram_req_arbiter_if #(
  parameter int NPORTS = 2,
  parameter int AW     = 16
);
  logic [NPORTS-1:0]    cl_cs;
  logic [NPORTS-1:0]    cl_oe;
  logic [NPORTS-1:0]    cl_we;
  logic [NPORTS*AW-1:0] cl_a;
  logic [NPORTS*8-1:0]  cl_d;
  logic [NPORTS*8-1:0]  cl_q;
  logic [NPORTS-1:0]    cl_valid;
  logic [NPORTS-1:0]    cl_busy;
  logic [NPORTS-1:0]    cl_ovr;
  logic                 sd_req;
  logic                 sd_ack;
  logic [AW-1:0]        sd_a;
  logic                 sd_we;
  logic [1:0]           sd_ds;
  logic [15:0]          sd_d;
  logic [15:0]          sd_q;
  logic                 sd_err;

  modport master (
    output cl_cs, cl_oe, cl_we, cl_a, cl_d, sd_ack, sd_q,
    input  cl_q, cl_valid, cl_busy, cl_ovr, sd_req, sd_a, sd_we, sd_ds, sd_d, sd_err
  );

  modport slave (
    input  cl_cs, cl_oe, cl_we, cl_a, cl_d, sd_ack, sd_q,
    output cl_q, cl_valid, cl_busy, cl_ovr, sd_req, sd_a, sd_we, sd_ds, sd_d, sd_err
  );
endinterface
`default_nettype wire

// File: rtl/sdram_req_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_req_arbiter                                                    |
// | Round-robin arbiter from NPORTS byte clients onto a toggle-handshake |
// | SDRAM port. Optional ack timeout enabled by SDRAM_ARB_TIMEOUT_EN.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sdram_req_arbiter #(
  parameter int NPORTS = 2,
  parameter int AW     = 16,
  parameter int TMO    = 255
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  sdram_req_arbiter_if.slave bus
);
  localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [1:0] c_sync = 2'd0;
  localparam logic [1:0] c_idle = 2'd1;
  localparam logic [1:0] c_wait = 2'd2;

  logic [1:0]           r_state, w_state_nxt;
  logic [NPORTS-1:0]    r_rd_prev, r_wr_prev, r_pend, r_pwe, r_infl, r_ovr, r_valid;
  logic [NPORTS*AW-1:0] r_a_prev, r_pa;
  logic [NPORTS*8-1:0]  r_pd, r_q;
  logic [GW-1:0]        r_last_grant, r_cur;
  logic                 r_sd_req, r_sd_we;
  logic [AW-1:0]        r_sd_a;
  logic [1:0]           r_sd_ds;
  logic [15:0]          r_sd_d;

  logic [NPORTS-1:0]    w_rd_all, w_wr_all, w_trig, w_trig_wr, w_issue_oh, w_fin_oh;
  logic [NPORTS-1:0]    w_pend_nxt, w_pwe_nxt, w_infl_nxt, w_ovr_nxt;
  logic [NPORTS*AW-1:0] w_pa_nxt;
  logic [NPORTS*8-1:0]  w_pd_nxt, w_q_nxt;
  logic                 w_ack_match, w_found, w_issue, w_done, w_tmo;
  logic [GW-1:0]        w_grant;
  logic [GW:0]          w_sum;
  logic [7:0]           w_rdata;
  logic [AW-1:0]        w_sel_a;
  logic [7:0]           w_sel_d;
  logic                 w_sel_we;

  assign w_ack_match = (bus.sd_ack == r_sd_req);

  // Search from last_grant+1 wrapping at NPORTS; the first pending slot wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = r_last_grant;
    w_sum   = '0;
    for (int k = 1; k <= NPORTS; k++) begin
      w_sum = {1'b0, r_last_grant} + (GW+1)'(k);
      if (w_sum >= (GW+1)'(NPORTS))
        w_sum = w_sum - (GW+1)'(NPORTS);
      if (!w_found && r_pend[w_sum[GW-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_sum[GW-1:0];
      end
    end
  end

  assign w_sel_a  = r_pa[w_grant*AW +: AW];
  assign w_sel_d  = r_pd[w_grant*8 +: 8];
  assign w_sel_we = r_pwe[w_grant];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= c_sync;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_sync:  if (w_ack_match) w_state_nxt = c_idle;
      c_idle:  if (w_found) w_state_nxt = c_wait;
      c_wait: begin
        if (w_ack_match)  w_state_nxt = c_idle;
        else if (w_tmo)   w_state_nxt = c_sync;
      end
      default: w_state_nxt = c_sync;
    endcase
  end

  always_comb begin
    w_issue = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      c_idle:  w_issue = w_found;
      c_wait:  w_done  = w_ack_match;
      default: ;
    endcase
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam logic [7:0] c_tmo_last = 8'(TMO - 1);
  logic [7:0] r_tmo_cnt;
  logic       r_sd_err;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
      r_sd_err  <= 1'b0;
    end else begin
      if (w_issue)               r_tmo_cnt <= '0;
      else if (r_state == c_wait) r_tmo_cnt <= r_tmo_cnt + 8'd1;
      if (w_tmo)                 r_sd_err  <= 1'b1;
    end
  end

  assign w_tmo      = (r_state == c_wait) && !w_ack_match && (r_tmo_cnt == c_tmo_last);
  assign bus.sd_err = r_sd_err;
`else
  assign w_tmo      = 1'b0;
  assign bus.sd_err = 1'b0;
`endif

  assign w_issue_oh = w_issue ? (NPORTS'(1) << w_grant) : '0;
  assign w_fin_oh   = (w_done | w_tmo) ? (NPORTS'(1) << r_cur) : '0;
  // A timed-out read returns FF so the client never sees stale data as fresh.
  assign w_rdata    = w_tmo ? 8'hFF : (r_sd_a[0] ? bus.sd_q[15:8] : bus.sd_q[7:0]);

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    logic w_a_chg, w_trig_rd, w_hold;
    assign w_rd_all[i]  = bus.cl_cs[i] & bus.cl_oe[i];
    assign w_wr_all[i]  = bus.cl_cs[i] & bus.cl_we[i];
    assign w_a_chg      = bus.cl_a[i*AW +: AW] != r_a_prev[i*AW +: AW];
    assign w_trig_rd    = w_rd_all[i] & (~r_rd_prev[i] | w_a_chg);
    assign w_trig_wr[i] = w_wr_all[i] & ~r_wr_prev[i];
    assign w_trig[i]    = w_trig_rd | w_trig_wr[i];
    // Slot still waiting after this edge (not being issued right now).
    assign w_hold       = r_pend[i] & ~w_issue_oh[i];

    assign w_pend_nxt[i]        = w_trig[i] | w_hold;
    assign w_ovr_nxt[i]         = r_ovr[i] | (w_trig[i] & w_hold);
    assign w_pwe_nxt[i]         = w_trig[i] ? w_trig_wr[i] : r_pwe[i];
    assign w_pa_nxt[i*AW +: AW] = w_trig[i] ? bus.cl_a[i*AW +: AW] : r_pa[i*AW +: AW];
    assign w_pd_nxt[i*8 +: 8]   = w_trig[i] ? bus.cl_d[i*8 +: 8] : r_pd[i*8 +: 8];
    assign w_infl_nxt[i]        = w_issue_oh[i] | (r_infl[i] & ~w_fin_oh[i]);
    assign w_q_nxt[i*8 +: 8]    = (w_fin_oh[i] & ~r_sd_we) ? w_rdata : r_q[i*8 +: 8];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_prev    <= '0;
      r_wr_prev    <= '0;
      r_a_prev     <= '0;
      r_pend       <= '0;
      r_pwe        <= '0;
      r_pa         <= '0;
      r_pd         <= '0;
      r_infl       <= '0;
      r_ovr        <= '0;
      r_valid      <= '0;
      r_q          <= '0;
      r_sd_req     <= 1'b0;
      r_sd_we      <= 1'b0;
      r_sd_a       <= '0;
      r_sd_ds      <= 2'b00;
      r_sd_d       <= 16'h0000;
      r_cur        <= '0;
      r_last_grant <= GW'(NPORTS - 1);
    end else begin
      r_rd_prev <= w_rd_all;
      r_wr_prev <= w_wr_all;
      r_a_prev  <= bus.cl_a;
      r_pend    <= w_pend_nxt;
      r_pwe     <= w_pwe_nxt;
      r_pa      <= w_pa_nxt;
      r_pd      <= w_pd_nxt;
      r_infl    <= w_infl_nxt;
      r_ovr     <= w_ovr_nxt;
      r_valid   <= w_fin_oh;
      r_q       <= w_q_nxt;
      if (w_issue) begin
        r_sd_req     <= ~r_sd_req;
        r_sd_a       <= w_sel_a;
        r_sd_we      <= w_sel_we;
        r_sd_ds      <= w_sel_we ? (w_sel_a[0] ? 2'b10 : 2'b01) : 2'b11;
        r_sd_d       <= {w_sel_d, w_sel_d};
        r_cur        <= w_grant;
        r_last_grant <= w_grant;
      end
    end
  end

  assign bus.cl_q     = r_q;
  assign bus.cl_valid = r_valid;
  assign bus.cl_busy  = r_pend | r_infl;
  assign bus.cl_ovr   = r_ovr;
  assign bus.sd_req   = r_sd_req;
  assign bus.sd_a     = r_sd_a;
  assign bus.sd_we    = r_sd_we;
  assign bus.sd_ds    = r_sd_ds;
  assign bus.sd_d     = r_sd_d;
endmodule
`default_nettype wire
